// File: rtl/lab1_sweep_pkg.sv
// Package shared by the lab-1 sweep controller and its settle timer.
// Holds the FSM state encoding, the vector geometry and the helper that
// sizes the settle counter from the programmed settle time.
package lab1_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int unsigned VEC_W   = 4;
    localparam int unsigned NUM_VEC = 16;

    // Settle counter must be able to hold SETTLE_CYCLES itself, since it
    // advances once more on the cycle that hands over to SAMPLE.
    function automatic int unsigned cnt_width(input int unsigned settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/lab1_sweep_controller_settle_timer.sv
// Settle timer: loadable up-counter with synchronous clear and enable.
// tc is high while the count equals SETTLE_CYCLES-1.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   clear       - synchronous clear to zero (highest priority)
//   load        - load load_value
//   load_value  - value taken when load is high
//   enable      - count up by one
//   tc          - terminal-count flag
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/lab1_sweep_controller.sv
// Lab-1 sweep controller: steps the 4-input circuit under test through all
// 16 input vectors (0000 -> 1111), waits SETTLE_CYCLES per vector, captures
// y_in into a truth table, counts ones and compares against EXPECTED.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   start        - request a sweep (sampled in IDLE only)
//   abort        - cancel a sweep in SETTLE/SAMPLE
//   y_in         - response of the circuit under test
//   G, T, U, E   - drive vector bits 3..0
//   busy         - high during SETTLE and SAMPLE
//   done         - one-cycle pulse when a sweep completes
//   truth        - captured table, bit k = y for vector k
//   ones         - number of ones captured so far
//   pass         - last completed sweep matched EXPECTED
module lab1_sweep_controller
    import lab1_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] EXPECTED      = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        y_in,
    output logic        G,
    output logic        T,
    output logic        U,
    output logic        E,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  ones,
    output logic        pass
);

    localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [15:0]      truth_next;
    logic             timer_clear;
    logic             timer_enable;
    logic             timer_tc;

    // Timer restarts on every entry into SETTLE and runs only inside it.
    assign timer_clear  = ((state == ST_IDLE) && start) || (state == ST_SAMPLE);
    assign timer_enable = (state == ST_SETTLE);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_settle_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .load      (1'b0),
        .load_value('0),
        .enable    (timer_enable),
        .tc        (timer_tc)
    );

    // Table including the sample taken this cycle, so pass can be judged
    // on the same edge that enters DONE.
    always_comb begin
        truth_next      = truth;
        truth_next[vec] = y_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            vec   <= '0;
            truth <= '0;
            ones  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    vec <= '0;
                    if (start) begin
                        state <= ST_SETTLE;
                        truth <= '0;
                        ones  <= '0;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        vec   <= '0;
                        busy  <= 1'b0;
                    end else if (timer_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        vec   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        truth <= truth_next;
                        ones  <= ones + {4'b0000, y_in};
                        if (vec == VEC_W'(NUM_VEC - 1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (truth_next == EXPECTED);
                        end else begin
                            state <= ST_SETTLE;
                            vec   <= vec + VEC_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    vec   <= '0;
                end
            endcase
        end
    end

    assign G = vec[3];
    assign T = vec[2];
    assign U = vec[1];
    assign E = vec[0];

endmodule

// File: tb/tb_lab1_sweep_controller.sv
// Bench for lab1_sweep_controller: three instances with different settle
// times / expected tables, each fed by a behavioural model of the lab
// circuit whose function is chosen per instance.
module tb_lab1_sweep_controller;

    typedef struct packed {
        logic [15:0] truth;
        logic [4:0]  ones;
        logic        pass;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  start_s;
    logic [2:0]  abort_s;
    logic [2:0]  y_s;
    logic [2:0]  g_s, t_s, u_s, e_s;
    logic [2:0]  busy_s, done_s, pass_s;
    logic [15:0] truth_s [3];
    logic [4:0]  ones_s  [3];
    int          mode_s  [3];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit-under-test models: 0 parity, 1 constant one, 2 G&T, 3 ~E.
    always_comb begin
        y_s = '0;
        for (int i = 0; i < 3; i++) begin
            case (mode_s[i])
                0:       y_s[i] = g_s[i] ^ t_s[i] ^ u_s[i] ^ e_s[i];
                1:       y_s[i] = 1'b1;
                2:       y_s[i] = g_s[i] & t_s[i];
                default: y_s[i] = ~e_s[i];
            endcase
        end
    end

    lab1_sweep_controller #(.SETTLE_CYCLES(2), .EXPECTED(16'h6996)) u_par (
        .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]), .y_in(y_s[0]),
        .G(g_s[0]), .T(t_s[0]), .U(u_s[0]), .E(e_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .truth(truth_s[0]), .ones(ones_s[0]), .pass(pass_s[0])
    );

    lab1_sweep_controller #(.SETTLE_CYCLES(2), .EXPECTED(16'h6997)) u_mis (
        .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]), .y_in(y_s[1]),
        .G(g_s[1]), .T(t_s[1]), .U(u_s[1]), .E(e_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .truth(truth_s[1]), .ones(ones_s[1]), .pass(pass_s[1])
    );

    lab1_sweep_controller #(.SETTLE_CYCLES(1), .EXPECTED(16'hF000)) u_min (
        .clk(clk), .reset(reset), .start(start_s[2]), .abort(abort_s[2]), .y_in(y_s[2]),
        .G(g_s[2]), .T(t_s[2]), .U(u_s[2]), .E(e_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .truth(truth_s[2]), .ones(ones_s[2]), .pass(pass_s[2])
    );

    function automatic logic [3:0] vec_of(input int i);
        return {g_s[i], t_s[i], u_s[i], e_s[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_compare(input int idx, input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_truth"}, 32'(truth_s[idx]), 32'(e.truth));
            chk({tag, "_ones"},  32'(ones_s[idx]),  32'(e.ones));
            chk({tag, "_pass"},  32'(pass_s[idx]),  32'(e.pass));
        end
    endtask

    // Full sweep on one instance: per-cycle vector check, done latency,
    // scoreboard compare at done, and the return to IDLE afterwards.
    task automatic run_sweep(input int idx, input int s, input string tag,
                             input logic [15:0] et, input logic [4:0] eo, input logic ep);
        int period;
        int k;
        period = 16 * (s + 1);
        exp_q.push_back('{truth: et, ones: eo, pass: ep});
        start_s[idx] = 1'b1;
        @(negedge clk);
        start_s[idx] = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy_s[idx]), 32'd1);
        for (k = 1; k <= period + 4; k++) begin
            @(negedge clk);
            if (done_s[idx]) break;
            if (k < period && vec_of(idx) !== 4'(k / (s + 1)))
                chk($sformatf("%s_vec_c%0d", tag, k), 32'(vec_of(idx)), 32'(k / (s + 1)));
        end
        chk({tag, "_done_at"}, 32'(k), 32'(period));
        chk({tag, "_busy_in_done"}, 32'(busy_s[idx]), 32'd0);
        chk({tag, "_vec_in_done"}, 32'(vec_of(idx)), 32'hF);
        pop_compare(idx, tag);
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(done_s[idx]), 32'd0);
        chk({tag, "_vec_idle"}, 32'(vec_of(idx)), 32'd0);
        chk({tag, "_truth_hold"}, 32'(truth_s[idx]), 32'(et));
    endtask

    initial begin
        int ndone;
        reset   = 1'b1;
        start_s = '0;
        abort_s = '0;
        mode_s  = '{0, 0, 2};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_truth", 32'(truth_s[0]), 32'd0);
        chk("rst_ones",  32'(ones_s[0]),  32'd0);
        chk("rst_pass",  32'(pass_s[0]),  32'd0);
        chk("rst_busy",  32'(busy_s[0]),  32'd0);
        chk("rst_done",  32'(done_s[0]),  32'd0);
        chk("rst_vec",   32'(vec_of(0)),  32'd0);

        // Parity circuit, matching table.
        run_sweep(0, 2, "parity", 16'h6996, 5'd8, 1'b1);

        // Parity circuit against a table that differs in bit 0.
        run_sweep(1, 2, "mismatch", 16'h6996, 5'd8, 1'b0);

        // Abort during vector 5 settle with y tied high.
        mode_s[0] = 1;
        exp_q.push_back('{truth: 16'h001F, ones: 5'd5, pass: 1'b0});
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        chk("abort_vec5", 32'(vec_of(0)), 32'd5);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("abort_busy", 32'(busy_s[0]), 32'd0);
        chk("abort_vec",  32'(vec_of(0)), 32'd0);
        pop_compare(0, "abort");
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done_s[0]) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_still_idle", 32'(busy_s[0]), 32'd0);

        // start and abort together in IDLE: start is accepted.
        mode_s[0] = 0;
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        chk("start_abort_busy", 32'(busy_s[0]), 32'd1);
        for (int k = 1; k <= 28; k++) @(negedge clk);
        chk("pre_reset_vec9", 32'(vec_of(0)), 32'd9);
        chk("pre_reset_truth", 32'(truth_s[0]), 32'h0196);

        // Asynchronous reset between edges.
        reset = 1'b1;
        #1;
        chk("areset_truth", 32'(truth_s[0]), 32'd0);
        chk("areset_ones",  32'(ones_s[0]),  32'd0);
        chk("areset_busy",  32'(busy_s[0]),  32'd0);
        chk("areset_vec",   32'(vec_of(0)),  32'd0);
        chk("areset_pass",  32'(pass_s[0]),  32'd0);
        chk("areset_done",  32'(done_s[0]),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_sweep(0, 2, "post_reset", 16'h6996, 5'd8, 1'b1);

        // start held high: back-to-back sweeps every 34 cycles.
        mode_s[2] = 2;
        exp_q.push_back('{truth: 16'hF000, ones: 5'd4, pass: 1'b1});
        exp_q.push_back('{truth: 16'hF000, ones: 5'd4, pass: 1'b1});
        start_s[2] = 1'b1;
        @(negedge clk);
        ndone = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done_s[2]) begin
                ndone++;
                chk($sformatf("held_done%0d_at", ndone), 32'(c), (ndone == 1) ? 32'd32 : 32'd66);
                pop_compare(2, "held");
                if (ndone == 2) begin
                    start_s[2] = 1'b0;
                    break;
                end
            end
        end
        chk("held_done_count", 32'(ndone), 32'd2);
        repeat (3) @(negedge clk);
        chk("held_stop_idle", 32'(busy_s[2]), 32'd0);

        // Minimum settle time with y = ~E.
        mode_s[2] = 3;
        run_sweep(2, 1, "minset", 16'h5555, 5'd8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
